// File: rtl/shifter_pkg.sv
// Shared types for the pipelined GRS mantissa shifter: shift mode, the
// {guard, round, sticky} triple and the barrel-level count helper.
package shifter_pkg;

    typedef enum logic {
        MODE_ALIGN = 1'b0,
        MODE_NORM  = 1'b1
    } mode_e;

    typedef struct packed {
        logic g;
        logic r;
        logic s;
    } grs_t;

    // One barrel level per bit of shift needed to clear {mant, G, R} entirely.
    function automatic int calc_levels(input int mant_width);
        return $clog2(mant_width + 3);
    endfunction

endpackage

// File: rtl/pipelined_grs_shifter_lzc.sv
// Combinational leading-zero counter; an all-zero input counts as WIDTH.
module lzc #(
    parameter int WIDTH = 24
) (
    input  logic [WIDTH-1:0]           value,
    output logic [$clog2(WIDTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/pipelined_grs_shifter.sv
// Pipelined mantissa shifter: align (right shift, exact sticky) or normalise
// (left shift by capped leading-zero count), barrel levels spread over PIPE_DEPTH stages.
module pipelined_grs_shifter
    import shifter_pkg::*;
#(
    parameter int MANT_WIDTH  = 24,
    parameter int SHIFT_WIDTH = 8,
    parameter int PIPE_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_mode,
    input  logic [MANT_WIDTH-1:0]  in_mant,
    input  logic [2:0]             in_grs,
    input  logic [SHIFT_WIDTH-1:0] in_shamt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [MANT_WIDTH-1:0]  out_mant,
    output logic [2:0]             out_grs,
    output logic [SHIFT_WIDTH-1:0] out_shamt,
    output logic                   out_zero
);

    localparam int EXT_W   = MANT_WIDTH + 2;
    localparam int LEVELS  = calc_levels(MANT_WIDTH);
    localparam int LZ_W    = $clog2(MANT_WIDTH + 1);
    localparam int BASE_L  = LEVELS / PIPE_DEPTH;
    localparam int EXTRA_L = LEVELS % PIPE_DEPTH;

    typedef struct packed {
        logic [MANT_WIDTH-1:0]  mant;
        grs_t                   grs;
        logic [LEVELS-1:0]      rem;
        mode_e                  mode;
        logic                   zero;
        logic [SHIFT_WIDTH-1:0] eff;
    } stage_t;

    // First barrel level owned by stage k; earlier stages absorb the leftover levels.
    function automatic int lvl_lo(input int k);
        return k * BASE_L + ((k < EXTRA_L) ? k : EXTRA_L);
    endfunction

    // Any align shift of EXT_W or more empties {mant, G, R}; clamp so it fits the barrel.
    function automatic logic [LEVELS-1:0] sat_align_shift(input logic [SHIFT_WIDTH-1:0] sh);
        if (sh >= SHIFT_WIDTH'(EXT_W)) begin
            return LEVELS'(EXT_W);
        end
        return sh[LEVELS-1:0];
    endfunction

    function automatic stage_t shift_levels(input stage_t d, input int lo, input int hi);
        stage_t           q;
        logic [EXT_W-1:0] ext;
        logic [EXT_W-1:0] lost;
        logic             sticky;
        q      = d;
        ext    = {d.mant, d.grs.g, d.grs.r};
        lost   = '0;
        sticky = d.grs.s;
        for (int l = 0; l < LEVELS; l++) begin
            if (l >= lo && l < hi && d.rem[l]) begin
                if (d.mode == MODE_NORM) begin
                    ext = ext << (1 << l);
                end else begin
                    lost   = ext & ~({EXT_W{1'b1}} << (1 << l));
                    sticky = sticky | (|lost);
                    ext    = ext >> (1 << l);
                end
            end
        end
        q.mant = ext[EXT_W-1:2];
        q.grs  = {ext[1], ext[0], sticky};
        return q;
    endfunction

    logic                   adv;
    logic [LZ_W-1:0]        lz;
    logic [SHIFT_WIDTH-1:0] lz_ext;
    stage_t                 s0;
    stage_t                 nxt    [PIPE_DEPTH];
    stage_t                 pipe_p [PIPE_DEPTH];
    logic                   vld_p  [PIPE_DEPTH];

    lzc #(
        .WIDTH (MANT_WIDTH)
    ) u_lzc (
        .value (in_mant),
        .count (lz)
    );

    // Stage 0: effective shift and zero flag, ahead of the first register
    always_comb begin
        lz_ext  = SHIFT_WIDTH'(lz);
        s0      = '0;
        s0.mant = in_mant;
        s0.grs  = in_grs;
        s0.mode = mode_e'(in_mode);
        s0.zero = (in_mant == '0) && (in_grs == 3'b000);
        if (in_mode) begin
            s0.eff = (lz_ext < in_shamt) ? lz_ext : in_shamt;
            s0.rem = s0.eff[LEVELS-1:0];
        end else begin
            s0.eff = in_shamt;
            s0.rem = sat_align_shift(in_shamt);
        end
    end

    assign nxt[0] = shift_levels(s0, lvl_lo(0), lvl_lo(1));

    for (genvar k = 1; k < PIPE_DEPTH; k++) begin : g_stage
        // Stage k: remaining barrel levels on the registered payload of stage k-1
        assign nxt[k] = shift_levels(pipe_p[k-1], lvl_lo(k), lvl_lo(k + 1));
    end

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                pipe_p[k] <= '0;
                vld_p[k]  <= 1'b0;
            end
        end else if (adv) begin
            vld_p[0] <= in_valid;
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                vld_p[k] <= vld_p[k-1];
            end
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                pipe_p[k] <= nxt[k];
            end
        end
    end

    // Output boundary: last register stage drives the result ports
    assign out_valid = vld_p[PIPE_DEPTH-1];
    assign out_mant  = pipe_p[PIPE_DEPTH-1].mant;
    assign out_grs   = pipe_p[PIPE_DEPTH-1].grs;
    assign out_shamt = pipe_p[PIPE_DEPTH-1].eff;
    assign out_zero  = pipe_p[PIPE_DEPTH-1].zero;

endmodule

// File: tb/tb_pipelined_grs_shifter.sv
// Scoreboard bench for pipelined_grs_shifter (MANT_WIDTH=24, PIPE_DEPTH=2).
module tb_pipelined_grs_shifter;

    localparam int MW = 24;
    localparam int SW = 8;
    localparam int PD = 2;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic          in_mode   = 1'b0;
    logic [MW-1:0] in_mant   = '0;
    logic [2:0]    in_grs    = '0;
    logic [SW-1:0] in_shamt  = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [MW-1:0] out_mant;
    logic [2:0]    out_grs;
    logic [SW-1:0] out_shamt;
    logic          out_zero;

    typedef struct {
        logic [MW-1:0] mant;
        logic [2:0]    grs;
        logic [SW-1:0] shamt;
        logic          zero;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    pipelined_grs_shifter #(
        .MANT_WIDTH  (MW),
        .SHIFT_WIDTH (SW),
        .PIPE_DEPTH  (PD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_mant   (in_mant),
        .in_grs    (in_grs),
        .in_shamt  (in_shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_grs   (out_grs),
        .out_shamt (out_shamt),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    function automatic exp_t mk(input logic [MW-1:0] m, input logic [2:0] g,
                                input logic [SW-1:0] s, input logic z);
        exp_t e;
        e.mant  = m;
        e.grs   = g;
        e.shamt = s;
        e.zero  = z;
        return e;
    endfunction

    function automatic exp_t model(input logic mode, input logic [MW-1:0] mant,
                                   input logic [2:0] grs, input logic [SW-1:0] sh);
        exp_t        e;
        logic [25:0] ext;
        logic        s;
        int          eff;
        int          lz;
        bit          found;
        ext = {mant, grs[2:1]};
        s   = grs[0];
        if (mode) begin
            lz    = MW;
            found = 0;
            for (int i = MW - 1; i >= 0; i--) begin
                if (!found && mant[i]) begin
                    lz    = MW - 1 - i;
                    found = 1;
                end
            end
            eff = (lz < int'(sh)) ? lz : int'(sh);
            ext = ext << eff;
        end else begin
            eff = int'(sh);
            if (eff >= 26) begin
                s   = s | (|ext);
                ext = '0;
            end else begin
                for (int i = 0; i < 26; i++) begin
                    if (i < eff) s = s | ext[i];
                end
                ext = ext >> eff;
            end
        end
        e.mant  = ext[25:2];
        e.grs   = {ext[1:0], s};
        e.shamt = SW'(eff);
        e.zero  = (mant == '0) && (grs == 3'b000);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got mant=%h grs=%b shamt=%0d with no beat outstanding",
                         out_mant, out_grs, out_shamt);
            end else begin
                e = sb.pop_front();
                if (out_mant !== e.mant || out_grs !== e.grs || out_shamt !== e.shamt ||
                    out_zero !== e.zero) begin
                    errors++;
                    $display("FAIL sb_result: got mant=%h grs=%b shamt=%0d zero=%b, expected mant=%h grs=%b shamt=%0d zero=%b",
                             out_mant, out_grs, out_shamt, out_zero, e.mant, e.grs, e.shamt, e.zero);
                end
            end
        end
    end

    task automatic send_exp(input logic mode, input logic [MW-1:0] mant, input logic [2:0] grs,
                            input logic [SW-1:0] sh, input exp_t e);
        int n;
        in_valid = 1'b1;
        in_mode  = mode;
        in_mant  = mant;
        in_grs   = grs;
        in_shamt = sh;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
            in_valid = 1'b0;
            return;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic mode, input logic [MW-1:0] mant, input logic [2:0] grs,
                        input logic [SW-1:0] sh);
        send_exp(mode, mant, grs, sh, model(mode, mant, grs, sh));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d beats still outstanding, required 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_latency(input string name);
        int n;
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!out_valid || n != PD) begin
            errors++;
            $display("FAIL %s: out_valid=%b after %0d cycles, required valid after %0d", name, out_valid, n, PD);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (out_valid !== 1'b0 || out_mant !== '0 || out_grs !== 3'b000 ||
            out_shamt !== '0 || out_zero !== 1'b0) begin
            errors++;
            $display("FAIL %s: got valid=%b mant=%h grs=%b shamt=%0d zero=%b, required all 0",
                     name, out_valid, out_mant, out_grs, out_shamt, out_zero);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset_outputs");
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_align_basic();
        send_exp(1'b0, 24'h800000, 3'b000, 8'd1, mk(24'h400000, 3'b000, 8'd1, 1'b0));
        check_latency("align_latency");
        drain();
    endtask

    task automatic test_align_cases();
        send_exp(1'b0, 24'h000007, 3'b000, 8'd4,  mk(24'h000000, 3'b011, 8'd4,  1'b0));
        send_exp(1'b0, 24'h000001, 3'b000, 8'd30, mk(24'h000000, 3'b001, 8'd30, 1'b0));
        send_exp(1'b0, 24'h000000, 3'b000, 8'd30, mk(24'h000000, 3'b000, 8'd30, 1'b1));
        send_exp(1'b0, 24'h800000, 3'b000, 8'd25, mk(24'h000000, 3'b010, 8'd25, 1'b0));
        send_exp(1'b0, 24'h800000, 3'b000, 8'd26, mk(24'h000000, 3'b001, 8'd26, 1'b0));
        send_exp(1'b0, 24'h800001, 3'b001, 8'd0,  mk(24'h800001, 3'b001, 8'd0,  1'b0));
        send_exp(1'b0, 24'hABCDEF, 3'b101, 8'd8,  mk(24'h00ABCD, 3'b111, 8'd8,  1'b0));
        send_exp(1'b0, 24'h000000, 3'b100, 8'd255, mk(24'h000000, 3'b001, 8'd255, 1'b0));
        drain();
    endtask

    task automatic test_normalise();
        send_exp(1'b1, 24'h001234, 3'b100, 8'd255, mk(24'h91A400, 3'b000, 8'd11, 1'b0));
        send_exp(1'b1, 24'h001234, 3'b100, 8'd4,   mk(24'h012348, 3'b000, 8'd4,  1'b0));
        send_exp(1'b1, 24'h000000, 3'b110, 8'd255, mk(24'hC00000, 3'b000, 8'd24, 1'b0));
        send_exp(1'b1, 24'h000000, 3'b000, 8'd255, mk(24'h000000, 3'b000, 8'd24, 1'b1));
        send_exp(1'b1, 24'h800000, 3'b111, 8'd255, mk(24'h800000, 3'b111, 8'd0,  1'b0));
        send_exp(1'b1, 24'h000001, 3'b011, 8'd10,  mk(24'h000500, 3'b001, 8'd10, 1'b0));
        drain();
    endtask

    task automatic test_back_to_back();
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send(1'b0, 24'h00ABCD << i, 3'(i), 8'(i * 3));
                end
            end
            begin
                logic [MW-1:0] h_mant;
                logic [2:0]    h_grs;
                logic [SW-1:0] h_shamt;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                h_mant  = out_mant;
                h_grs   = out_grs;
                h_shamt = out_shamt;
                repeat (3) begin
                    @(negedge clk);
                    checks++;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL stall_handshake: in_ready=%b out_valid=%b, required 0 and 1",
                                 in_ready, out_valid);
                    end
                    checks++;
                    if (out_mant !== h_mant || out_grs !== h_grs || out_shamt !== h_shamt) begin
                        errors++;
                        $display("FAIL stall_hold: got mant=%h grs=%b shamt=%0d, required mant=%h grs=%b shamt=%0d",
                                 out_mant, out_grs, out_shamt, h_mant, h_grs, h_shamt);
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
    endtask

    task automatic test_reset_mid();
        send(1'b0, 24'h800000, 3'b000, 8'd1);
        send(1'b1, 24'h00F000, 3'b010, 8'd255);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_inflight: out_valid=%b before reset, required 1", out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("reset_mid_outputs");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(1'b0, 24'h123456, 3'b010, 8'd3);
        check_latency("reset_mid_latency");
        drain();
    endtask

    task automatic test_random();
        bit done;
        done = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [MW-1:0] m;
                    logic [SW-1:0] s;
                    m = MW'($urandom() >> $urandom_range(8, 31));
                    s = ($urandom_range(0, 7) == 0) ? SW'($urandom_range(26, 255))
                                                    : SW'($urandom_range(0, 27));
                    send(1'($urandom_range(0, 1)), m, 3'($urandom_range(0, 7)), s);
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
    endtask

    initial begin
        test_reset();
        test_align_basic();
        test_align_cases();
        test_normalise();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_grs_shifter.md
Name: pipelined_grs_shifter

Overview:
- Parametrised, pipelined successor to the single-cycle mantissa shifter used in Stage 1 (exponent alignment) and Stage 3 (normalisation).
- Takes a mantissa plus guard/round/sticky (GRS) bits. Align mode right-shifts with exact sticky accumulation. Normalise mode left-shifts by the leading-zero count, capped by a caller-supplied limit.
- Barrel stages are split across PIPE_DEPTH register stages behind a valid/ready handshake, so it drops between pipeline stages of the FP datapath.

Parameters:
- MANT_WIDTH, 24, mantissa width in bits, legal 8..64.
- SHIFT_WIDTH, 8, shift-amount width; must satisfy 2^SHIFT_WIDTH > MANT_WIDTH+3.
- PIPE_DEPTH, 2, register stages (= latency), legal 1..clog2(MANT_WIDTH+3).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts beat this cycle.
- in_mode  in  1  0 = align (right), 1 = normalise (left).
- in_mant  in  MANT_WIDTH  mantissa.
- in_grs  in  3  {guard, round, sticky}.
- in_shamt  in  SHIFT_WIDTH  align: shift amount; normalise: maximum permitted left shift.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_mant  out  MANT_WIDTH  shifted mantissa.
- out_grs  out  3  resulting {G,R,S}.
- out_shamt  out  SHIFT_WIDTH  shift actually applied.
- out_zero  out  1  input mantissa and GRS all zero.

Behaviour:
- Reset: all stage valid bits 0, all data registers 0. So out_valid=0, out_mant=0, out_grs=0, out_shamt=0, out_zero=0. Reset mid-stream discards every in-flight beat.
- Handshake: global advance enable adv = !out_valid || out_ready. in_ready = adv.
  - Beat accepted when in_valid && in_ready.
  - When adv=0 all stages hold and outputs stay stable.
  - Bubbles advance like beats (valid bit 0); no bubble collapsing.
- Latency: exactly PIPE_DEPTH cycles from acceptance to out_valid, given no stall. Throughput is one beat per cycle.
- Stage 0 (combinational before the first register):
  - Compute the effective shift and out_zero.
  - Normalise mode uses the lzc sub-module on in_mant: eff = min(lzc(in_mant), in_shamt).
  - Align mode: eff = in_shamt.
- Barrel levels (1,2,4,...) are distributed as evenly as possible across the PIPE_DEPTH stages; any extra levels go to the earliest stages.
- Align arithmetic: operate on the extended vector {mant, G, R} of width MANT_WIDTH+2, with sticky kept separately.
  - Right shift by eff; every bit shifted below R position is ORed into S.
  - eff >= MANT_WIDTH+2: out_mant=0, G=R=0, S = OR(in_mant, in_grs).
  - eff=0: pass through unchanged.
- Normalise arithmetic: left shift {mant, G, R} by eff, filling zeros; S is unchanged.
  - lzc of all-zero mantissa = MANT_WIDTH; it is still capped by in_shamt.
  - in_mant=0: out_zero = !(|in_grs); the shift proceeds normally.
- out_shamt = eff, unmodified, in both modes.
- Simultaneous accept and emit under out_ready=1 is lossless.
- in_valid=0 while in_ready=1 inserts a bubble.
- Inputs are not required to be held after acceptance.

Decomposition:
- Package shifter_pkg holds:
  - mode enum: MODE_ALIGN=0, MODE_NORM=1.
  - packed struct grs_t {g, r, s}.
  - function calc_levels(MANT_WIDTH) = clog2(MANT_WIDTH+3).
  - stage-payload struct: mant, grs, remaining shift, mode, zero, eff.
- One sub-module, lzc, is natural: parametrised leading-zero counter, MANT_WIDTH in, clog2(MANT_WIDTH+1) out, purely combinational.

Test Plan (MANT_WIDTH=24, PIPE_DEPTH=2):
- Align, in_mant=0x800000, grs=000, shamt=1 -> out_mant=0x400000, grs=000, out_shamt=1, out_valid exactly 2 cycles after accept.
- Align sticky, in_mant=0x000007, grs=000, shamt=4 -> out_mant=0x000000, grs=011.
- Align overflow, in_mant=0x000001, grs=000, shamt=30 -> out_mant=0, grs=001.
  - Same with in_mant=0 and grs=000 -> grs=000, out_zero=1.
- Normalise, in_mant=0x001234, grs=100, shamt=255 -> out_mant=0x91A400, grs=000, out_shamt=11.
  - Same with shamt=4 -> out_mant=0x012348, out_shamt=4.
- Back-to-back stream of 10 align beats; out_ready dropped for 3 cycles mid-stream:
  - in_ready=0 during the stall; outputs held constant.
  - All 10 results delivered in order with no loss or duplication.
- Assert rst asynchronously with 2 beats in flight -> out_valid=0 and all outputs 0 immediately.
  - After release, the first new beat emerges with latency 2.
